// File: rtl/hazard_sb.sv
// hazard_sb: pipeline hazard scoreboard, forwarding select,
// MDU hold FSM and stall/flush performance counters.
//
// Ports:
//   clk, resetn            clock, async active-low reset
//   ra                     D-stage sources, port i at [i*AW +: AW]
//   e/m/w_wa, e/m/w_wen    destination and write enable per stage
//   e_is_load, e_mdu       E instruction is a load / mul-div
//   pc_sel                 redirect resolved in E
//   imem_wait, dmem_wait   memory not ready
//   pc/f/d/e/m_ctl         00 stream, 01 flush, 11 keep
//   fwd_sel                per port: 00 rf, 01 E, 10 M, 11 W
//   mdu_busy               FSM in RUN
//   stall_cnt, flush_cnt   saturating event counters
module hazard_sb #(
  parameter int NRP     = 2,
  parameter int AW      = 5,
  parameter int MDU_LAT = 4,
  parameter int CW      = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NRP*AW-1:0] ra,
  input  logic [AW-1:0]     e_wa,
  input  logic [AW-1:0]     m_wa,
  input  logic [AW-1:0]     w_wa,
  input  logic              e_wen,
  input  logic              m_wen,
  input  logic              w_wen,
  input  logic              e_is_load,
  input  logic              e_mdu,
  input  logic              pc_sel,
  input  logic              imem_wait,
  input  logic              dmem_wait,
  output logic [1:0]        pc_ctl,
  output logic [1:0]        f_ctl,
  output logic [1:0]        d_ctl,
  output logic [1:0]        e_ctl,
  output logic [1:0]        m_ctl,
  output logic [NRP*2-1:0]  fwd_sel,
  output logic              mdu_busy,
  output logic [CW-1:0]     stall_cnt,
  output logic [CW-1:0]     flush_cnt
);

  localparam int CNTW = $clog2(MDU_LAT) + 1;

  localparam logic [1:0] STRM = 2'b00;
  localparam logic [1:0] FLSH = 2'b01;
  localparam logic [1:0] KEEP = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CW-1:0]   stall_q, stall_d;
  logic [CW-1:0]   flush_q, flush_d;

  logic mdu_hold;
  logic load_use;
  logic redirect;

  // Hold covers the issue cycle plus MDU_LAT-1 RUN cycles;
  // the cnt==0 RUN cycle only holds while dmem is stalling.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mdu_hold = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (e_mdu) begin
          mdu_hold = 1'b1;
          state_d  = RUN;
          cnt_d    = CNTW'(MDU_LAT - 1);
        end
      end
      RUN: begin
        if (cnt_q != '0) begin
          mdu_hold = 1'b1;
          cnt_d    = cnt_q - CNTW'(1);
        end else if (dmem_wait) begin
          mdu_hold = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    load_use = 1'b0;
    fwd_sel  = '0;
    for (int i = 0; i < NRP; i++) begin
      if (ra[i*AW +: AW] != '0) begin
        if (e_wen && e_is_load &&
            e_wa == ra[i*AW +: AW])
          load_use = 1'b1;
        // A load result is not ready in E.
        if (e_wen && !e_is_load &&
            e_wa == ra[i*AW +: AW])
          fwd_sel[i*2 +: 2] = 2'b01;
        else if (m_wen &&
                 m_wa == ra[i*AW +: AW])
          fwd_sel[i*2 +: 2] = 2'b10;
        else if (w_wen &&
                 w_wa == ra[i*AW +: AW])
          fwd_sel[i*2 +: 2] = 2'b11;
      end
    end
    if (!resetn)
      fwd_sel = '0;
  end

  always_comb begin
    pc_ctl   = STRM;
    f_ctl    = STRM;
    d_ctl    = STRM;
    e_ctl    = STRM;
    m_ctl    = STRM;
    redirect = 1'b0;
    if (!resetn) begin
      pc_ctl = KEEP;
      f_ctl  = FLSH;
      d_ctl  = FLSH;
      e_ctl  = FLSH;
      m_ctl  = FLSH;
    end else if (dmem_wait || mdu_hold) begin
      pc_ctl = KEEP;
      f_ctl  = KEEP;
      d_ctl  = KEEP;
      e_ctl  = KEEP;
      m_ctl  = FLSH;
    end else if (imem_wait) begin
      pc_ctl = KEEP;
      f_ctl  = FLSH;
      // Keep the redirect alive in E until
      // the fetch side can take it.
      if (pc_sel) begin
        d_ctl = KEEP;
        e_ctl = FLSH;
      end
    end else if (pc_sel) begin
      f_ctl    = FLSH;
      d_ctl    = FLSH;
      redirect = 1'b1;
    end else if (load_use) begin
      pc_ctl = KEEP;
      f_ctl  = KEEP;
      d_ctl  = FLSH;
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (pc_ctl == KEEP && stall_q != '1)
      stall_d = stall_q + CW'(1);
    if (redirect && flush_q != '1)
      flush_d = flush_q + CW'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign mdu_busy  = (state_q == RUN);
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_hazard_sb.sv
// tb_hazard_sb: table vectors, directed MDU/reset
// sequences and random stimulus against a reference model.
module tb_hazard_sb;

  localparam int NRP = 2;
  localparam int AW  = 5;
  localparam int LAT = 4;
  localparam int CW  = 8;
  localparam int SAT = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              resetn;
  logic [NRP*AW-1:0] ra;
  logic [AW-1:0]     e_wa, m_wa, w_wa;
  logic              e_wen, m_wen, w_wen;
  logic              e_is_load, e_mdu, pc_sel;
  logic              imem_wait, dmem_wait;
  logic [1:0]        pc_ctl, f_ctl, d_ctl, e_ctl, m_ctl;
  logic [NRP*2-1:0]  fwd_sel;
  logic              mdu_busy;
  logic [CW-1:0]     stall_cnt, flush_cnt;

  int checks   = 0;
  int failures = 0;

  // Model: op in flight and cycles elapsed since it issued.
  bit mb    = 0;
  int mprog = 0;
  int mstall = 0;
  int mflush = 0;
  logic [1:0]       xpc, xf, xd, xe, xm;
  logic [NRP*2-1:0] xfwd;
  bit               xp4;

  typedef struct {
    logic [NRP*AW-1:0] ra;
    logic [AW-1:0]     ewa, mwa, wwa;
    logic [2:0]        wen;
    logic              ld, psel, imw, dmw;
    logic [1:0]        pc, f, d, e, m;
    logic [NRP*2-1:0]  fwd;
    int                sinc, finc;
  } vec_t;

  vec_t tv[10];

  hazard_sb #(
    .NRP(NRP), .AW(AW), .MDU_LAT(LAT), .CW(CW)
  ) dut (
    .clk(clk), .resetn(resetn), .ra(ra),
    .e_wa(e_wa), .m_wa(m_wa), .w_wa(w_wa),
    .e_wen(e_wen), .m_wen(m_wen), .w_wen(w_wen),
    .e_is_load(e_is_load), .e_mdu(e_mdu),
    .pc_sel(pc_sel), .imem_wait(imem_wait),
    .dmem_wait(dmem_wait),
    .pc_ctl(pc_ctl), .f_ctl(f_ctl), .d_ctl(d_ctl),
    .e_ctl(e_ctl), .m_ctl(m_ctl),
    .fwd_sel(fwd_sel), .mdu_busy(mdu_busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic void model_comb();
    bit hold, lu;
    logic [AW-1:0] r;
    xpc = 2'b00; xf = 2'b00; xd = 2'b00;
    xe = 2'b00; xm = 2'b00; xfwd = '0;
    xp4 = 0; lu = 0;
    if (!resetn) begin
      xpc = 2'b11; xf = 2'b01; xd = 2'b01;
      xe = 2'b01; xm = 2'b01;
      return;
    end
    for (int i = 0; i < NRP; i++) begin
      r = ra[i*AW +: AW];
      if (r != 0 && e_wen && e_is_load && e_wa == r)
        lu = 1;
      if (r == 0)
        xfwd[i*2 +: 2] = 2'b00;
      else if (e_wen && e_wa == r && !e_is_load)
        xfwd[i*2 +: 2] = 2'b01;
      else if (m_wen && m_wa == r)
        xfwd[i*2 +: 2] = 2'b10;
      else if (w_wen && w_wa == r)
        xfwd[i*2 +: 2] = 2'b11;
    end
    if (mb)
      hold = (mprog < LAT) || dmem_wait;
    else
      hold = e_mdu;
    if (dmem_wait || hold) begin
      xpc = 2'b11; xf = 2'b11; xd = 2'b11;
      xe = 2'b11; xm = 2'b01;
    end else if (imem_wait) begin
      xpc = 2'b11; xf = 2'b01;
      if (pc_sel) begin
        xd = 2'b11; xe = 2'b01;
      end
    end else if (pc_sel) begin
      xf = 2'b01; xd = 2'b01; xp4 = 1;
    end else if (lu) begin
      xpc = 2'b11; xf = 2'b11; xd = 2'b01;
    end
  endfunction

  function automatic void model_tick();
    if (xpc == 2'b11 && mstall < SAT) mstall++;
    if (xp4 && mflush < SAT) mflush++;
    if (!mb) begin
      if (e_mdu) begin
        mb = 1; mprog = 1;
      end
    end else if (mprog >= LAT && !dmem_wait) begin
      mb = 0;
    end else begin
      mprog++;
    end
  endfunction

  function automatic void model_reset();
    mb = 0; mprog = 0; mstall = 0; mflush = 0;
  endfunction

  task automatic cycle(input string tg);
    #1;
    model_comb();
    chk({tg, ".pc"}, 32'(pc_ctl), 32'(xpc));
    chk({tg, ".f"}, 32'(f_ctl), 32'(xf));
    chk({tg, ".d"}, 32'(d_ctl), 32'(xd));
    chk({tg, ".e"}, 32'(e_ctl), 32'(xe));
    chk({tg, ".m"}, 32'(m_ctl), 32'(xm));
    chk({tg, ".fwd"}, 32'(fwd_sel), 32'(xfwd));
    chk({tg, ".busy"}, 32'(mdu_busy), 32'(mb));
    chk({tg, ".stall"}, 32'(stall_cnt), mstall);
    chk({tg, ".flush"}, 32'(flush_cnt), mflush);
    @(posedge clk);
    if (resetn) model_tick();
    @(negedge clk);
  endtask

  task automatic idle_in();
    ra = '0; e_wa = '0; m_wa = '0; w_wa = '0;
    e_wen = 0; m_wen = 0; w_wen = 0;
    e_is_load = 0; e_mdu = 0; pc_sel = 0;
    imem_wait = 0; dmem_wait = 0;
  endtask

  initial begin
    tv[0] = '{{5'd3, 5'd0}, 5'd3, 5'd0, 5'd0, 3'b100,
              1, 0, 0, 0, 2'b11, 2'b11, 2'b01, 2'b00,
              2'b00, 4'b0000, 1, 0};
    tv[1] = '{{5'd3, 5'd0}, 5'd3, 5'd0, 5'd0, 3'b100,
              0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00,
              2'b00, 4'b0100, 0, 0};
    tv[2] = '{{5'd3, 5'd0}, 5'd3, 5'd0, 5'd0, 3'b100,
              0, 1, 1, 0, 2'b11, 2'b01, 2'b11, 2'b01,
              2'b00, 4'b0100, 1, 0};
    tv[3] = '{{5'd3, 5'd0}, 5'd3, 5'd0, 5'd0, 3'b100,
              0, 1, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00,
              2'b00, 4'b0100, 0, 1};
    tv[4] = '{{5'd0, 5'd7}, 5'd0, 5'd7, 5'd7, 3'b011,
              0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00,
              2'b00, 4'b0010, 0, 0};
    tv[5] = '{{5'd0, 5'd0}, 5'd0, 5'd0, 5'd0, 3'b111,
              1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00,
              2'b00, 4'b0000, 0, 0};
    tv[6] = '{{5'd0, 5'd7}, 5'd0, 5'd7, 5'd0, 3'b010,
              0, 1, 0, 1, 2'b11, 2'b11, 2'b11, 2'b11,
              2'b01, 4'b0010, 1, 0};
    tv[7] = '{{5'd9, 5'd0}, 5'd0, 5'd0, 5'd9, 3'b001,
              0, 0, 1, 0, 2'b11, 2'b01, 2'b00, 2'b00,
              2'b00, 4'b1100, 1, 0};
    tv[8] = '{{5'd3, 5'd0}, 5'd3, 5'd0, 5'd0, 3'b100,
              1, 1, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00,
              2'b00, 4'b0000, 0, 1};
    tv[9] = '{{5'd3, 5'd3}, 5'd3, 5'd3, 5'd0, 3'b110,
              1, 0, 0, 0, 2'b11, 2'b11, 2'b01, 2'b00,
              2'b00, 4'b1010, 1, 0};

    // Reset state, with busy-looking inputs.
    idle_in();
    resetn = 0;
    e_mdu = 1; pc_sel = 1;
    ra = {5'd3, 5'd3}; m_wen = 1; m_wa = 5'd3;
    #3;
    chk("rst.pc", 32'(pc_ctl), 32'h3);
    chk("rst.m", 32'(m_ctl), 32'h1);
    chk("rst.fwd", 32'(fwd_sel), 32'h0);
    chk("rst.busy", 32'(mdu_busy), 32'h0);
    chk("rst.stall", 32'(stall_cnt), 32'h0);
    @(negedge clk);
    cycle("rst");
    cycle("rst");
    idle_in();
    resetn = 1;

    // Table vectors.
    for (int k = 0; k < 10; k++) begin
      int s0, f0;
      ra = tv[k].ra;
      e_wa = tv[k].ewa; m_wa = tv[k].mwa;
      w_wa = tv[k].wwa;
      {e_wen, m_wen, w_wen} = tv[k].wen;
      e_is_load = tv[k].ld; pc_sel = tv[k].psel;
      imem_wait = tv[k].imw; dmem_wait = tv[k].dmw;
      e_mdu = 0;
      s0 = mstall; f0 = mflush;
      #1;
      chk($sformatf("tv%0d.pc", k), 32'(pc_ctl),
          32'(tv[k].pc));
      chk($sformatf("tv%0d.f", k), 32'(f_ctl),
          32'(tv[k].f));
      chk($sformatf("tv%0d.d", k), 32'(d_ctl),
          32'(tv[k].d));
      chk($sformatf("tv%0d.e", k), 32'(e_ctl),
          32'(tv[k].e));
      chk($sformatf("tv%0d.m", k), 32'(m_ctl),
          32'(tv[k].m));
      chk($sformatf("tv%0d.fwd", k), 32'(fwd_sel),
          32'(tv[k].fwd));
      cycle($sformatf("tv%0d", k));
      chk($sformatf("tv%0d.sinc", k),
          32'(stall_cnt), s0 + tv[k].sinc);
      chk($sformatf("tv%0d.finc", k),
          32'(flush_cnt), f0 + tv[k].finc);
    end
    idle_in();
    cycle("gap");

    // One MDU op: held cycles 1..4, streams on 5.
    e_mdu = 1;
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk($sformatf("mdu.c%0d.e", c), 32'(e_ctl),
          (c <= 4) ? 32'h3 : 32'h0);
      if (c == 1)
        chk("mdu.c1.busy", 32'(mdu_busy), 32'h0);
      if (c >= 2 && c <= 4)
        chk($sformatf("mdu.c%0d.busy", c),
            32'(mdu_busy), 32'h1);
      cycle($sformatf("mdu.c%0d", c));
    end
    e_mdu = 0;
    cycle("mdu.idle");

    // dmem_wait at cnt==0 for 2 cycles extends hold.
    e_mdu = 1;
    for (int c = 1; c <= 7; c++) begin
      dmem_wait = (c == 5 || c == 6);
      #1;
      chk($sformatf("dmw.c%0d.e", c), 32'(e_ctl),
          (c <= 6) ? 32'h3 : 32'h0);
      chk($sformatf("dmw.c%0d.m", c), 32'(m_ctl),
          (c <= 6) ? 32'h1 : 32'h0);
      cycle($sformatf("dmw.c%0d", c));
    end
    idle_in();
    cycle("dmw.idle");

    // Reset mid-RUN, then a full hold after release.
    e_mdu = 1;
    cycle("rr.a");
    cycle("rr.b");
    #2;
    resetn = 0;
    #1;
    chk("rr.busy", 32'(mdu_busy), 32'h0);
    chk("rr.stall", 32'(stall_cnt), 32'h0);
    chk("rr.flush", 32'(flush_cnt), 32'h0);
    chk("rr.pc", 32'(pc_ctl), 32'h3);
    model_reset();
    @(negedge clk);
    cycle("rr.in");
    resetn = 1;
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk($sformatf("rr.c%0d.e", c), 32'(e_ctl),
          (c <= 4) ? 32'h3 : 32'h0);
      cycle($sformatf("rr.c%0d", c));
    end
    idle_in();
    cycle("rr.idle");

    // Stall counter saturation.
    imem_wait = 1;
    for (int c = 0; c < SAT + 5; c++)
      cycle("sat");
    chk("sat.stall", 32'(stall_cnt), SAT);
    idle_in();
    cycle("sat.end");

    // Random stimulus against the model.
    for (int c = 0; c < 500; c++) begin
      ra = {5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3))};
      e_wa = 5'($urandom_range(0, 3));
      m_wa = 5'($urandom_range(0, 3));
      w_wa = 5'($urandom_range(0, 3));
      e_wen = 1'($urandom);
      m_wen = 1'($urandom);
      w_wen = 1'($urandom);
      e_is_load = 1'($urandom);
      e_mdu = ($urandom_range(0, 7) == 0);
      pc_sel = ($urandom_range(0, 3) == 0);
      imem_wait = ($urandom_range(0, 4) == 0);
      dmem_wait = ($urandom_range(0, 5) == 0);
      cycle("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
